// File: rtl/fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb
//   Round-robin burst arbiter sharing the async_fifo write port among NREQ
//   requesters in the wclk domain. A grant is held until the owner's word
//   marked `last` is written. Each burst costs one arbitration cycle in IDLE.
//   wfull back-pressure holds the pending word until it can be written.
//
// Optional feature (macro FIFO_ARB_WDOG_EN):
//   Stall watchdog. Counts GRANT cycles in which the owner is not requesting.
//   Reaching TMO aborts the burst, pulses err and moves the rr pointer past
//   the aborted owner. Without the macro, err is tied low.
//
// Parameters
//   DSIZE  data word width (matches async_fifo)
//   NREQ   number of requesters, 2..8
//   TMO    watchdog stall limit in cycles, 1..255 (watchdog build only)
//
// Ports
//   wclk   in   write-domain clock
//   wrst   in   asynchronous active-high reset
//   req    in   per-requester word valid
//   last   in   per-requester end-of-burst flag, qualified by req
//   din    in   per-requester data, requester i on [i*DSIZE +: DSIZE]
//   ack    out  one-hot word-accepted strobe (combinational)
//   owner  out  one-hot current grant (registered), 0 when idle
//   busy   out  high while a burst is granted (registered)
//   err    out  one-cycle watchdog abort pulse (registered)
//   wfull  in   FIFO full flag
//   winc   out  FIFO write strobe, = |ack
//   wdata  out  owner's data slice, zero when idle
// -----------------------------------------------------------------------------
module fifo_wr_arb #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4,
    parameter int TMO   = 16
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       last,
    input  logic [NREQ*DSIZE-1:0] din,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       owner,
    output logic                  busy,
    output logic                  err,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] owner_nxt;
    logic [PW-1:0]   idx, idx_nxt;      // binary index of the current owner
    logic [PW-1:0]   rr_ptr, rr_nxt;    // first requester to consider next
    logic [PW-1:0]   pick;
    logic            pick_vld;
    logic [CW-1:0]   cand;
    logic            done;
    logic            abort;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (i == PW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // Owner is only non-zero in GRANT, so masking with it gates ack to GRANT.
    assign ack  = wfull ? '0 : (req & owner);
    assign winc = |ack;
    assign done = |(ack & last);

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner[i]) wdata = din[i*DSIZE +: DSIZE];
        end
    end

    // Rotating priority search starting at rr_ptr, wrapping modulo NREQ.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
            if (!pick_vld && req[cand[PW-1:0]]) begin
                pick     = cand[PW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        idx_nxt   = idx;
        rr_nxt    = rr_ptr;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = GRANT;
                    idx_nxt   = pick;
                    owner_nxt = NREQ'(1) << pick;
                end
            end
            GRANT: begin
                if (done || abort) begin
                    state_nxt = IDLE;
                    owner_nxt = '0;
                    rr_nxt    = next_idx(idx);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so all state updates see
    // the pre-edge values, independent of statement order.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state  <= IDLE;
            owner  <= '0;
            idx    <= '0;
            rr_ptr <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            idx    <= idx_nxt;
            rr_ptr <= rr_nxt;
            busy   <= (state_nxt == GRANT);
        end
    end

`ifdef FIFO_ARB_WDOG_EN
    logic [7:0] stall_cnt;
    logic       stall;
    logic       err_q;

    // Only cycles where the owner has no word count; a full FIFO with a
    // pending word neither counts nor clears.
    assign stall = (state == GRANT) && !(|(req & owner));
    assign abort = stall && ((stall_cnt + 8'd1) == 8'(TMO));
    assign err   = err_q;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= abort;
            if (state != GRANT || winc || abort) stall_cnt <= '0;
            else if (stall)                      stall_cnt <= stall_cnt + 8'd1;
        end
    end
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

endmodule
